// File: rtl/pattern_matcher.sv
// 7x7 template matcher: scores each complete window by sum of absolute
// differences against a writable template, flags matches under a threshold
// and tracks the lowest-scoring window of the current frame.
module pattern_matcher #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_start,
    input  logic        win_valid,
    input  logic [55:0] win_row0,
    input  logic [55:0] win_row1,
    input  logic [55:0] win_row2,
    input  logic [55:0] win_row3,
    input  logic [55:0] win_row4,
    input  logic [55:0] win_row5,
    input  logic [55:0] win_row6,
    input  logic        tmpl_we,
    input  logic [5:0]  tmpl_addr,
    input  logic [7:0]  tmpl_data,
    input  logic [13:0] threshold,
    output logic        score_valid,
    output logic [13:0] score,
    output logic        match,
    output logic [9:0]  match_x,
    output logic [9:0]  match_y,
    output logic [13:0] best_score,
    output logic [9:0]  best_x,
    output logic [9:0]  best_y,
    output logic        frame_done
);

    localparam logic [9:0]  COL_LAST  = 10'(IMG_WIDTH - 1);
    localparam logic [9:0]  ROW_LAST  = 10'(IMG_HEIGHT - 1);
    localparam logic [13:0] BEST_INIT = 14'h3FFF;

    function automatic logic [7:0] absdiff(input logic [7:0] a, input logic [7:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

    logic [55:0] rows [7];
    assign rows[0] = win_row0;
    assign rows[1] = win_row1;
    assign rows[2] = win_row2;
    assign rows[3] = win_row3;
    assign rows[4] = win_row4;
    assign rows[5] = win_row5;
    assign rows[6] = win_row6;

    logic [9:0]  col_q, row_q;
    logic [7:0]  tmpl_q [49];

    logic [7:0]  ad_p1_q [49];
    logic [10:0] rsum_d [7];
    logic [10:0] rsum_p2_q [7];
    logic [13:0] total_d;
    logic [13:0] total_p3_q;
    logic [9:0]  cx_p1_q, cx_p2_q, cx_p3_q;
    logic [9:0]  cy_p1_q, cy_p2_q, cy_p3_q;
    logic        vld_p1_q, vld_p2_q, vld_p3_q;
    logic        upd_p1_q, upd_p2_q, upd_p3_q;
    logic        last_p1_q, last_p2_q, last_p3_q;

    // A coincident frame_start makes the entering pixel (0,0).
    logic [9:0] cur_col, cur_row;
    logic       win_complete, win_last;
    assign cur_col      = frame_start ? 10'd0 : col_q;
    assign cur_row      = frame_start ? 10'd0 : row_q;
    assign win_complete = win_valid && (cur_col >= 10'd6) && (cur_row >= 10'd6);
    assign win_last     = win_valid && (cur_col == COL_LAST) && (cur_row == ROW_LAST);

    // Raster position of the next pixel to enter the window.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_q <= '0;
            row_q <= '0;
        end else if (win_valid) begin
            if (cur_col == COL_LAST) begin
                col_q <= '0;
                row_q <= (cur_row == ROW_LAST) ? 10'd0 : cur_row + 10'd1;
            end else begin
                col_q <= cur_col + 10'd1;
                row_q <= cur_row;
            end
        end else if (frame_start) begin
            col_q <= '0;
            row_q <= '0;
        end
    end

    // Template storage; addresses past the 49 cells are dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 49; i++) tmpl_q[i] <= '0;
        end else if (tmpl_we && (tmpl_addr < 6'd49)) begin
            tmpl_q[tmpl_addr] <= tmpl_data;
        end
    end

    // Adder trees for the row sums and the window total.
    always_comb begin
        for (int r = 0; r < 7; r++) begin : g_row
            logic [10:0] acc;
            acc = '0;
            for (int c = 0; c < 7; c++) acc = acc + 11'(ad_p1_q[r*7+c]);
            rsum_d[r] = acc;
        end
        total_d = '0;
        for (int r = 0; r < 7; r++) total_d = total_d + 14'(rsum_p2_q[r]);
    end

    // Datapath registers: no reset, qualified by the valid flags.
    always_ff @(posedge clk) begin
        // S1: per-cell absolute differences and window centre
        for (int r = 0; r < 7; r++)
            for (int c = 0; c < 7; c++)
                ad_p1_q[r*7+c] <= absdiff(rows[r][55-8*c -: 8], tmpl_q[r*7+c]);
        cx_p1_q <= cur_col - 10'd3;
        cy_p1_q <= cur_row - 10'd3;
        // S2: row sums
        for (int r = 0; r < 7; r++) rsum_p2_q[r] <= rsum_d[r];
        cx_p2_q <= cx_p1_q;
        cy_p2_q <= cy_p1_q;
        // S3: window total
        total_p3_q <= total_d;
        cx_p3_q    <= cx_p2_q;
        cy_p3_q    <= cy_p2_q;
    end

    // Control flags riding alongside the datapath; frame_start revokes
    // best-tracker eligibility of windows still in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p1_q  <= 1'b0; vld_p2_q  <= 1'b0; vld_p3_q  <= 1'b0;
            upd_p1_q  <= 1'b0; upd_p2_q  <= 1'b0; upd_p3_q  <= 1'b0;
            last_p1_q <= 1'b0; last_p2_q <= 1'b0; last_p3_q <= 1'b0;
        end else begin
            vld_p1_q  <= win_complete;
            upd_p1_q  <= win_complete;
            last_p1_q <= win_last;
            vld_p2_q  <= vld_p1_q;
            upd_p2_q  <= upd_p1_q && !frame_start;
            last_p2_q <= last_p1_q;
            vld_p3_q  <= vld_p2_q;
            upd_p3_q  <= upd_p2_q && !frame_start;
            last_p3_q <= last_p2_q;
        end
    end

    // S4: registered outputs, threshold compare and best tracker.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            score_valid <= 1'b0;
            score       <= '0;
            match       <= 1'b0;
            match_x     <= '0;
            match_y     <= '0;
            frame_done  <= 1'b0;
            best_score  <= BEST_INIT;
            best_x      <= '0;
            best_y      <= '0;
        end else begin
            score_valid <= vld_p3_q;
            frame_done  <= vld_p3_q && last_p3_q;
            match       <= vld_p3_q && (total_p3_q <= threshold);
            if (vld_p3_q) begin
                score   <= total_p3_q;
                match_x <= cx_p3_q;
                match_y <= cy_p3_q;
            end
            if (frame_start) begin
                best_score <= BEST_INIT;
                best_x     <= '0;
                best_y     <= '0;
            end else if (vld_p3_q && upd_p3_q && (total_p3_q < best_score)) begin
                best_score <= total_p3_q;
                best_x     <= cx_p3_q;
                best_y     <= cy_p3_q;
            end
        end
    end

endmodule

// File: tb/tb_pattern_matcher.sv
// Bench for pattern_matcher on an 8x8 image: a frame-level image/template
// reference model feeds an expectation queue, a negedge monitor checks output.
`timescale 1ns/1ps
module tb_pattern_matcher;

    localparam int W = 8;
    localparam int H = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        frame_start = 1'b0;
    logic        win_valid = 1'b0;
    logic [55:0] win_row0 = '0, win_row1 = '0, win_row2 = '0, win_row3 = '0;
    logic [55:0] win_row4 = '0, win_row5 = '0, win_row6 = '0;
    logic        tmpl_we = 1'b0;
    logic [5:0]  tmpl_addr = '0;
    logic [7:0]  tmpl_data = '0;
    logic [13:0] threshold = '0;
    logic        score_valid, match, frame_done;
    logic [13:0] score, best_score;
    logic [9:0]  match_x, match_y, best_x, best_y;

    pattern_matcher #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk(clk), .reset(reset), .frame_start(frame_start), .win_valid(win_valid),
        .win_row0(win_row0), .win_row1(win_row1), .win_row2(win_row2), .win_row3(win_row3),
        .win_row4(win_row4), .win_row5(win_row5), .win_row6(win_row6),
        .tmpl_we(tmpl_we), .tmpl_addr(tmpl_addr), .tmpl_data(tmpl_data), .threshold(threshold),
        .score_valid(score_valid), .score(score), .match(match),
        .match_x(match_x), .match_y(match_y),
        .best_score(best_score), .best_x(best_x), .best_y(best_y), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int score; bit m; int x; int y; bit fd; int best; int bx; int by; longint t;
    } exp_t;
    exp_t q[$];

    // Reference model state: the image being streamed and the template.
    int img [H][W];
    int tmpl [49];
    int thr;
    int m_best, m_bx, m_by;

    task automatic chk(input string name, input longint act, input longint expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic int sad(input int x, input int y);
        int s = 0;
        int d;
        for (int dy = 0; dy < 7; dy++)
            for (int dx = 0; dx < 7; dx++) begin
                d = img[y-6+dy][x-6+dx] - tmpl[dy*7+dx];
                s += (d < 0) ? -d : d;
            end
        return s;
    endfunction

    task automatic model_best_clear();
        m_best = 16383; m_bx = 0; m_by = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            win_valid = 1'b0;
            frame_start = 1'b0;
        end
    endtask

    // Present the 7x7 neighbourhood ending at image pixel (x,y); cells off
    // the image are filled with junk since such windows are never scored.
    task automatic drive_pixel(input int x, input int y, input bit fs, input bit expect_out);
        logic [55:0] rw [7];
        logic [7:0]  v;
        int yy, xx;
        exp_t e;
        @(posedge clk); #1;
        for (int r = 0; r < 7; r++)
            for (int c = 0; c < 7; c++) begin
                yy = y - 6 + r;
                xx = x - 6 + c;
                v = (yy >= 0 && xx >= 0) ? 8'(img[yy][xx]) : 8'($urandom);
                rw[r][55-8*c -: 8] = v;
            end
        win_row0 = rw[0]; win_row1 = rw[1]; win_row2 = rw[2]; win_row3 = rw[3];
        win_row4 = rw[4]; win_row5 = rw[5]; win_row6 = rw[6];
        win_valid = 1'b1;
        frame_start = fs;
        if (fs) model_best_clear();
        if (expect_out && x >= 6 && y >= 6) begin
            e.score = sad(x, y);
            e.m = (e.score <= thr);
            e.x = x - 3;
            e.y = y - 3;
            e.fd = (x == W-1) && (y == H-1);
            if (e.score < m_best) begin m_best = e.score; m_bx = e.x; m_by = e.y; end
            e.best = m_best; e.bx = m_bx; e.by = m_by;
            e.t = cyc;
            q.push_back(e);
        end
    endtask

    task automatic run_frame(input bit fs_first, input bit gaps);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
                drive_pixel(x, y, fs_first && x == 0 && y == 0, 1'b1);
                if (gaps && $urandom_range(0, 3) == 0) idle(1);
            end
        idle(7);
    endtask

    task automatic do_frame_start();
        @(posedge clk); #1;
        frame_start = 1'b1;
        win_valid = 1'b0;
        model_best_clear();
        @(posedge clk); #1;
        frame_start = 1'b0;
        chk("fs_best_score", best_score, 14'h3FFF);
        chk("fs_best_xy", {best_x, best_y}, 20'd0);
    endtask

    task automatic set_tmpl(input int a, input int d);
        @(posedge clk); #1;
        tmpl_we = 1'b1;
        tmpl_addr = 6'(a);
        tmpl_data = 8'(d);
        if (a < 49) tmpl[a] = d;
    endtask

    task automatic tmpl_end();
        @(posedge clk); #1;
        tmpl_we = 1'b0;
    endtask

    task automatic fill_tmpl(input bit rnd, input int v);
        for (int i = 0; i < 49; i++) set_tmpl(i, rnd ? int'($urandom_range(0, 255)) : v);
        tmpl_end();
    endtask

    task automatic fill_img(input bit rnd, input int v);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) img[y][x] = rnd ? int'($urandom_range(0, 255)) : v;
    endtask

    task automatic set_thr(input int t);
        thr = t;
        threshold = 14'(t);
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        exp_t e;
        if (score_valid) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_score: score_valid=1 score=%0d, expected no output", score);
            end else begin
                e = q.pop_front();
                chk("latency", cyc, e.t + 4);
                chk("score", score, e.score);
                chk("match", match, e.m);
                chk("match_x", match_x, e.x);
                chk("match_y", match_y, e.y);
                chk("frame_done", frame_done, e.fd);
                chk("best_score", best_score, e.best);
                chk("best_x", best_x, e.bx);
                chk("best_y", best_y, e.by);
            end
        end else if (frame_done) begin
            checks++;
            errors++;
            $display("FAIL frame_done_alone: frame_done=1 with score_valid=0, expected 0");
        end
    end

    initial begin
        for (int i = 0; i < 49; i++) tmpl[i] = 0;
        model_best_clear();
        set_thr(0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_score_valid", score_valid, 0);
        chk("rst_score", score, 0);
        chk("rst_match", match, 0);
        chk("rst_match_xy", {match_x, match_y}, 0);
        chk("rst_best_score", best_score, 14'h3FFF);
        chk("rst_best_xy", {best_x, best_y}, 0);
        chk("rst_frame_done", frame_done, 0);

        // identical window and template
        fill_tmpl(1'b0, 8'h10);
        fill_img(1'b0, 8'h10);
        set_thr(0);
        do_frame_start();
        run_frame(1'b0, 1'b0);

        // maximum score, one above threshold
        fill_tmpl(1'b0, 0);
        fill_img(1'b0, 8'hFF);
        set_thr(12494);
        do_frame_start();
        run_frame(1'b0, 1'b0);

        // single template cell; out-of-range address ignored
        set_tmpl(24, 8'h80);
        set_tmpl(55, 8'h77);
        tmpl_end();
        fill_img(1'b0, 0);
        set_thr(8'h80);
        do_frame_start();
        run_frame(1'b0, 1'b0);

        // tie between centres (3,3) and (4,3)
        set_tmpl(24, 0);
        tmpl_end();
        fill_img(1'b0, 0);
        img[7][7] = 200;
        img[7][0] = 100;
        set_thr(50);
        do_frame_start();
        run_frame(1'b0, 1'b0);
        chk("tie_best_score", best_score, 0);
        chk("tie_best_x", best_x, 3);
        chk("tie_best_y", best_y, 3);

        // random frames, one with coincident frame_start, one with gaps
        for (int k = 0; k < 3; k++) begin
            fill_tmpl(1'b1, 0);
            fill_img(1'b1, 0);
            set_thr($urandom_range(3000, 5500));
            if (k != 1) do_frame_start();
            run_frame(k == 1, k == 2);
        end

        // reset two cycles after a complete window enters
        fill_img(1'b1, 0);
        do_frame_start();
        for (int y = 0; y < 7; y++)
            for (int x = 0; x < W; x++)
                if (y < 6 || x <= 6) drive_pixel(x, y, 1'b0, 1'b0);
        idle(1);
        @(posedge clk); #1;
        reset = 1'b1;
        for (int i = 0; i < 49; i++) tmpl[i] = 0;
        model_best_clear();
        @(negedge clk);
        chk("mid_rst_score_valid", score_valid, 0);
        chk("mid_rst_score", score, 0);
        chk("mid_rst_match", match, 0);
        chk("mid_rst_best_score", best_score, 14'h3FFF);
        chk("mid_rst_match_xy", {match_x, match_y}, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        idle(8);
        chk("post_rst_best_score", best_score, 14'h3FFF);

        // frame after reset: template cleared, counters restart at (0,0)
        fill_img(1'b1, 0);
        set_thr($urandom_range(2000, 6000));
        run_frame(1'b0, 1'b1);

        for (int i = 0; i < 40 && q.size() != 0; i++) @(posedge clk);
        chk("drain_pending", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
